corevx_mem_arbiter: RTL and testbench
=====================================

Name: corevx_mem_arbiter

Overview:
Two-master to one-slave arbiter for the memory bus downstream of the caches. The instruction cache and data cache each drive one upstream port. The block forwards one granted master's request to the shared memory port with zero added latency. It keeps that grant until the master's whole burst completes: all read data beats returned, or all write beats accepted. Masters are served round-robin, with no starvation.

Parameters:
ADDR_WIDTH, 34, physical address width (matches cache m_address)
BURST_WIDTH, 5, burstcount width; legal bursts are 1..16, and 0 is treated as 1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
sN_address  input  ADDR_WIDTH  master N request address (N = 0,1; port 0 = icache, port 1 = dcache)
sN_burstcount  input  BURST_WIDTH  master N burst length
sN_read  input  1  master N read request
sN_write  input  1  master N write request
sN_writedata  input  32  master N write data
sN_byteenable  input  4  master N byte enables
sN_waitrequest  output  1  stall to master N
sN_readdata  output  32  read data to master N
sN_readdatavalid  output  1  read beat valid to master N
sN_response  output  2  response to master N
m_address  output  ADDR_WIDTH  to memory
m_burstcount  output  BURST_WIDTH  to memory
m_read  output  1  to memory
m_write  output  1  to memory
m_writedata  output  32  to memory
m_byteenable  output  4  to memory
m_waitrequest  input  1  memory stall
m_readdata  input  32  memory read data
m_readdatavalid  input  1  memory read beat valid
m_response  input  2  memory response (2'b00 OKAY, anything else is an error)

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset state:
  - state = IDLE, beats_left = 0, grant = 0.
  - Priority pointer favours master 0.
  - m_read = m_write = 0.
  - sN_waitrequest = 1, sN_readdatavalid = 0, sN_response = 2'b11.
- Request definition: reqN = sN_read | sN_write. If both strobes are high on one master, the access is treated as a read and sN_write is ignored.
- IDLE arbitration (combinational winner, same cycle):
  - If only one master requests, it wins.
  - If both request, the master flagged by the priority pointer wins.
- Forwarding: the winner's request fields drive m_* in the same cycle.
  - Winner: sN_waitrequest = m_waitrequest.
  - Loser: waitrequest = 1, readdatavalid = 0, response = 2'b11.
- Return path: m_readdata and m_response always go to the currently granted or winning master. m_response also passes through on write acceptance, because memory reports the write response together with waitrequest low.
- IDLE, read accepted (m_read & !m_waitrequest):
  - Latch grant.
  - beats_left = eff_burst − m_readdatavalid, because memory may return the first beat in the accept cycle.
  - If beats_left = 0, stay in IDLE and rotate priority; otherwise go to READ_DATA.
- READ_DATA:
  - m_read = m_write = 0, and both masters see waitrequest = 1.
  - m_readdatavalid and m_readdata are routed to the granted master.
  - beats_left decrements on each valid beat. On the last beat, go to IDLE and set priority to the other master.
  - Beats beyond the expected count are dropped.
- IDLE, write accepted (m_write & !m_waitrequest):
  - If eff_burst = 1, stay in IDLE and rotate priority.
  - Otherwise latch grant, set beats_left = eff_burst − 1 and go to WRITE_BURST.
- WRITE_BURST:
  - Only the granted master is forwarded; the other master is stalled.
  - beats_left decrements on each accepted beat. On the last beat, go to IDLE and rotate priority.
  - If the granted master drops sN_write mid-burst, the block waits with no timeout.
- Stray beats: m_readdatavalid in IDLE with no accepted read is ignored and not forwarded.
- Priority rule: the pointer changes only when a transaction completes. It then points to the non-served master.
- Reset mid-burst: the block returns immediately to reset state. Outstanding memory beats arriving afterwards are ignored per the stray-beat rule.

Test Plan:
- Single read from s0 to 0x0, burst 1; memory returns 32'hBEAFDEAD in the accept cycle -> s0_readdatavalid = 1 with that data in that same cycle; block stays in IDLE; s1 never sees valid.
- Simultaneous s0 and s1 reads out of reset -> s0 is served first; s1_waitrequest = 1 until s0's last beat; s1 then wins on the next IDLE cycle. Repeat -> order alternates 0,1,0,1.
- s1 read burst 16 starting at 0x40 -> exactly 16 s1_readdatavalid pulses with the correct memory words; s0 request is stalled throughout; return to IDLE after beat 16.
- s1 write burst 4, 32'hFFCC2211 with byteenable 4'hF, while s0 requests a read -> all 4 beats reach memory contiguously, with no s0 beat interleaved; s0 is granted afterwards.
- Read with m_response = 2'b11 on the data beat -> the granted master receives response 2'b11 with readdatavalid = 1.
- rst_n asserted during beat 3 of a 16-beat read -> outputs take reset values immediately; late memory beats produce no sN_readdatavalid; a fresh s0 read is served normally.

Source files
------------

// File: rtl/corevx_mem_arbiter.sv
// Two-master to one-slave memory bus arbiter. Port 0 is the icache and port 1
// is the dcache. The winning request is forwarded combinationally to the
// memory port. The grant is held until the burst completes, and masters are
// served round-robin.
module corevx_mem_arbiter #(
  parameter int ADDR_WIDTH  = 34,
  parameter int BURST_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  s0_address,
  input  logic [BURST_WIDTH-1:0] s0_burstcount,
  input  logic                   s0_read,
  input  logic                   s0_write,
  input  logic [31:0]            s0_writedata,
  input  logic [3:0]             s0_byteenable,
  output logic                   s0_waitrequest,
  output logic [31:0]            s0_readdata,
  output logic                   s0_readdatavalid,
  output logic [1:0]             s0_response,
  input  logic [ADDR_WIDTH-1:0]  s1_address,
  input  logic [BURST_WIDTH-1:0] s1_burstcount,
  input  logic                   s1_read,
  input  logic                   s1_write,
  input  logic [31:0]            s1_writedata,
  input  logic [3:0]             s1_byteenable,
  output logic                   s1_waitrequest,
  output logic [31:0]            s1_readdata,
  output logic                   s1_readdatavalid,
  output logic [1:0]             s1_response,
  output logic [ADDR_WIDTH-1:0]  m_address,
  output logic [BURST_WIDTH-1:0] m_burstcount,
  output logic                   m_read,
  output logic                   m_write,
  output logic [31:0]            m_writedata,
  output logic [3:0]             m_byteenable,
  input  logic                   m_waitrequest,
  input  logic [31:0]            m_readdata,
  input  logic                   m_readdatavalid,
  input  logic [1:0]             m_response
);

  localparam logic [BURST_WIDTH-1:0] BEAT_ONE = BURST_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, READ_DATA, WRITE_BURST} state_t;

  state_t                 r_state, w_state_nxt;
  logic [BURST_WIDTH-1:0] r_beats_left, w_beats_nxt;
  logic                   r_grant, w_grant_nxt;
  logic                   r_prio, w_prio_nxt;   // 0 favours master 0

  logic                   w_req0, w_req1, w_any_req, w_win, w_sel;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [BURST_WIDTH-1:0] w_sel_burst, w_eff_burst;
  logic                   w_sel_read, w_sel_write;
  logic [31:0]            w_sel_wdata;
  logic [3:0]             w_sel_be;
  logic                   w_fwd_wait, w_fwd_rdv;
  logic [1:0]             w_fwd_resp;

  assign w_req0    = s0_read | s0_write;
  assign w_req1    = s1_read | s1_write;
  assign w_any_req = w_req0 | w_req1;
  // Contention goes to the pointer; otherwise whoever asks (master 0 when idle).
  assign w_win     = (w_req0 & w_req1) ? r_prio : w_req1;
  // In IDLE the live winner steers the bus; during a burst the held grant does.
  assign w_sel     = (r_state == IDLE) ? w_win : r_grant;

  assign w_sel_addr  = w_sel ? s1_address    : s0_address;
  assign w_sel_burst = w_sel ? s1_burstcount : s0_burstcount;
  assign w_sel_read  = w_sel ? s1_read       : s0_read;
  assign w_sel_write = w_sel ? s1_write      : s0_write;
  assign w_sel_wdata = w_sel ? s1_writedata  : s0_writedata;
  assign w_sel_be    = w_sel ? s1_byteenable : s0_byteenable;
  // A zero burstcount is a single beat.
  assign w_eff_burst = (w_sel_burst == '0) ? BEAT_ONE : w_sel_burst;

  // State, remaining-beat count, grant and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beats_left <= '0;
      r_grant      <= 1'b0;
      r_prio       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beats_left <= w_beats_nxt;
      r_grant      <= w_grant_nxt;
      r_prio       <= w_prio_nxt;
    end
  end

  // Next-state logic plus memory-side forwarding and return-path steering.
  always_comb begin
    w_state_nxt  = r_state;
    w_beats_nxt  = r_beats_left;
    w_grant_nxt  = r_grant;
    w_prio_nxt   = r_prio;
    m_address    = w_sel_addr;
    m_burstcount = w_sel_burst;
    m_writedata  = w_sel_wdata;
    m_byteenable = w_sel_be;
    m_read       = 1'b0;
    m_write      = 1'b0;
    w_fwd_wait   = 1'b1;
    w_fwd_rdv    = 1'b0;
    w_fwd_resp   = 2'b11;
    case (r_state)
      IDLE: begin
        // rst_n gating keeps the memory strobes and master stalls at their
        // reset values while reset is held, even if masters keep requesting.
        if (rst_n && w_any_req) begin
          m_read     = w_sel_read;
          m_write    = w_sel_write & ~w_sel_read;
          w_fwd_wait = m_waitrequest;
          w_fwd_resp = m_response;
          if (m_read && !m_waitrequest) begin
            // Memory may hand back the first beat in the accept cycle.
            w_fwd_rdv   = m_readdatavalid;
            w_grant_nxt = w_win;
            w_beats_nxt = w_eff_burst - {{(BURST_WIDTH-1){1'b0}}, m_readdatavalid};
            if (w_beats_nxt == '0) w_prio_nxt  = ~w_win;
            else                   w_state_nxt = READ_DATA;
          end else if (m_write && !m_waitrequest) begin
            if (w_eff_burst == BEAT_ONE) begin
              w_prio_nxt = ~w_win;
            end else begin
              w_grant_nxt = w_win;
              w_beats_nxt = w_eff_burst - BEAT_ONE;
              w_state_nxt = WRITE_BURST;
            end
          end
        end
      end
      READ_DATA: begin
        w_fwd_resp = m_response;
        // Beats past the expected count are dropped.
        if (m_readdatavalid && (r_beats_left != '0)) begin
          w_fwd_rdv   = 1'b1;
          w_beats_nxt = r_beats_left - BEAT_ONE;
          if (r_beats_left == BEAT_ONE) begin
            w_state_nxt = IDLE;
            w_prio_nxt  = ~r_grant;
          end
        end
      end
      WRITE_BURST: begin
        // Only the granted master drives memory; a dropped strobe simply waits.
        m_write    = w_sel_write;
        w_fwd_wait = m_waitrequest;
        w_fwd_resp = m_response;
        if (m_write && !m_waitrequest) begin
          w_beats_nxt = r_beats_left - BEAT_ONE;
          if (r_beats_left == BEAT_ONE) begin
            w_state_nxt = IDLE;
            w_prio_nxt  = ~r_grant;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s0_waitrequest   = w_sel ? 1'b1  : w_fwd_wait;
  assign s0_readdatavalid = ~w_sel & w_fwd_rdv;
  assign s0_response      = w_sel ? 2'b11 : w_fwd_resp;
  assign s0_readdata      = w_sel ? 32'h0 : m_readdata;
  assign s1_waitrequest   = w_sel ? w_fwd_wait : 1'b1;
  assign s1_readdatavalid = w_sel & w_fwd_rdv;
  assign s1_response      = w_sel ? w_fwd_resp : 2'b11;
  assign s1_readdata      = w_sel ? m_readdata : 32'h0;

endmodule

// File: tb/tb_corevx_mem_arbiter.sv
// Scoreboard bench for corevx_mem_arbiter: directed memory-side stimulus pushes
// expected beats into queues, and a negedge monitor pops them as the DUT
// presents read beats to a master or write beats to memory.
module tb_corevx_mem_arbiter;

  localparam int AW = 34;
  localparam int BW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] s0_address, s1_address, m_address;
  logic [BW-1:0] s0_burstcount, s1_burstcount, m_burstcount;
  logic          s0_read, s0_write, s1_read, s1_write;
  logic [31:0]   s0_writedata, s1_writedata, m_writedata;
  logic [3:0]    s0_byteenable, s1_byteenable, m_byteenable;
  logic          s0_waitrequest, s1_waitrequest;
  logic [31:0]   s0_readdata, s1_readdata;
  logic          s0_readdatavalid, s1_readdatavalid;
  logic [1:0]    s0_response, s1_response;
  logic          m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [31:0]   m_readdata;
  logic [1:0]    m_response;

  int n_checks = 0;
  int n_err    = 0;

  logic [33:0] q0[$];   // {response, data} expected at master 0
  logic [33:0] q1[$];   // {response, data} expected at master 1
  logic [35:0] qw[$];   // {byteenable, data} expected at memory write accept

  int rr_order [4] = '{0, 1, 0, 1};
  int wr_wait  [6] = '{0, 0, 1, 0, 0, 0};
  int wr_strb  [6] = '{1, 1, 1, 0, 1, 1};

  corevx_mem_arbiter #(.ADDR_WIDTH(AW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_address(s0_address), .s0_burstcount(s0_burstcount), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid), .s0_response(s0_response),
    .s1_address(s1_address), .s1_burstcount(s1_burstcount), .s1_read(s1_read),
    .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_response(s1_response),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
    .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .m_response(m_response)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (s0_readdatavalid === 1'b1) begin
      if (q0.size() == 0) chk("s0_unexpected_beat", {s0_response, s0_readdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("s0_beat", {s0_response, s0_readdata}, q0.pop_front());
    end
    if (s1_readdatavalid === 1'b1) begin
      if (q1.size() == 0) chk("s1_unexpected_beat", {s1_response, s1_readdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("s1_beat", {s1_response, s1_readdata}, q1.pop_front());
    end
    if (m_write === 1'b1 && m_waitrequest === 1'b0) begin
      if (qw.size() == 0) chk("m_unexpected_write", {m_byteenable, m_writedata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("m_write_beat", {m_byteenable, m_writedata}, qw.pop_front());
    end
  end

  // Drive n read beats from memory for master `who`, checking both stall paths.
  task automatic beats(input int who, input int n, input logic [31:0] base, input logic [1:0] resp);
    for (int i = 0; i < n; i++) begin
      m_readdatavalid = 1'b1;
      m_readdata      = base + 32'(i);
      m_response      = resp;
      if (who == 0) q0.push_back({resp, base + 32'(i)});
      else          q1.push_back({resp, base + 32'(i)});
      @(negedge clk);
      chk("burst_no_m_read", m_read, 0);
      chk("burst_other_wait", (who == 0) ? s1_waitrequest : s0_waitrequest, 1);
      chk("burst_other_resp", (who == 0) ? s1_response : s0_response, 2'b11);
      tick();
    end
    m_readdatavalid = 1'b0;
    m_response      = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s0_address = '0; s0_burstcount = '0; s0_read = 1'b0; s0_write = 1'b0;
    s0_writedata = '0; s0_byteenable = '0;
    s1_address = '0; s1_burstcount = '0; s1_read = 1'b0; s1_write = 1'b0;
    s1_writedata = '0; s1_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0; m_response = 2'b00;

    // Reset values, first with idle masters and then with requests held.
    @(negedge clk);
    chk("rst_s0_wait", s0_waitrequest, 1);
    chk("rst_s1_wait", s1_waitrequest, 1);
    chk("rst_s0_resp", s0_response, 2'b11);
    chk("rst_s1_resp", s1_response, 2'b11);
    chk("rst_s0_rdv", s0_readdatavalid, 0);
    chk("rst_s1_rdv", s1_readdatavalid, 0);
    s0_read = 1'b1; s1_write = 1'b1;
    #1;
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_req_s0_wait", s0_waitrequest, 1);
    tick();
    s0_read = 1'b0; s1_write = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single read, data returned in the accept cycle.
    s0_read = 1'b1; s0_address = 34'h0; s0_burstcount = 5'd1;
    m_readdatavalid = 1'b1; m_readdata = 32'hBEAF_DEAD;
    q0.push_back({2'b00, 32'hBEAF_DEAD});
    @(negedge clk);
    chk("single_m_read", m_read, 1);
    chk("single_m_addr", m_address, 34'h0);
    chk("single_s0_wait", s0_waitrequest, 0);
    tick();
    // Stray beat with no request must be swallowed.
    s0_read = 1'b0;
    @(negedge clk);
    chk("single_back_idle_wait", s0_waitrequest, 1);
    tick();
    m_readdatavalid = 1'b0;

    // Round-robin between two always-requesting masters, out of reset.
    do_reset();
    s0_address = 34'h100; s1_address = 34'h200;
    s0_burstcount = 5'd2; s1_burstcount = 5'd2;
    s0_read = 1'b1; s1_read = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("rr_winner_addr", m_address, (rr_order[r] == 0) ? 34'h100 : 34'h200);
      chk("rr_loser_wait", (rr_order[r] == 0) ? s1_waitrequest : s0_waitrequest, 1);
      tick();
      if (rr_order[r] == 0) s0_read = 1'b0; else s1_read = 1'b0;
      beats(rr_order[r], 2, 32'h1000_0000 + 32'(r * 16), 2'b00);
      if (rr_order[r] == 0) s0_read = 1'b1; else s1_read = 1'b1;
    end
    s0_read = 1'b0; s1_read = 1'b0;

    // 16-beat read on master 1 while master 0 waits.
    s1_read = 1'b1; s1_address = 34'h40; s1_burstcount = 5'd16;
    @(negedge clk);
    chk("b16_m_addr", m_address, 34'h40);
    chk("b16_s1_wait", s1_waitrequest, 0);
    tick();
    s1_read = 1'b0;
    s0_read = 1'b1; s0_address = 34'h300; s0_burstcount = 5'd1;
    beats(1, 16, 32'hA000_0000, 2'b00);
    // Extra beat while memory stalls master 0's request: dropped.
    m_waitrequest = 1'b1; m_readdatavalid = 1'b1; m_readdata = 32'hDEAD_0000;
    @(negedge clk);
    chk("b16_after_m_read", m_read, 1);
    chk("b16_after_m_addr", m_address, 34'h300);
    chk("b16_after_s0_wait", s0_waitrequest, 1);
    tick();
    m_waitrequest = 1'b0; m_readdata = 32'h0000_1234;
    q0.push_back({2'b00, 32'h0000_1234});
    @(negedge clk);
    chk("b16_s0_served", s0_waitrequest, 0);
    tick();
    m_readdatavalid = 1'b0; s0_read = 1'b0;

    // Write burst of 4 on master 1 with a stall and a strobe gap; master 0 reads.
    s1_write = 1'b1; s1_address = 34'h80; s1_burstcount = 5'd4;
    s1_writedata = 32'hFFCC_2211; s1_byteenable = 4'hF;
    s0_read = 1'b1;
    for (int i = 0; i < 4; i++) qw.push_back({4'hF, 32'hFFCC_2211});
    for (int i = 0; i < 6; i++) begin
      m_waitrequest = wr_wait[i][0];
      s1_write      = wr_strb[i][0];
      @(negedge clk);
      chk("wr_no_m_read", m_read, 0);
      chk("wr_s0_stall", s0_waitrequest, 1);
      chk("wr_m_write", m_write, wr_strb[i][0]);
      chk("wr_s1_wait", s1_waitrequest, wr_wait[i][0]);
      if (i == 0) chk("wr_s1_resp", s1_response, 2'b00);
      tick();
    end
    s1_write = 1'b0; m_waitrequest = 1'b0;

    // Master 0 now granted; its single beat carries an error response.
    m_readdatavalid = 1'b1; m_readdata = 32'h5555_AAAA; m_response = 2'b11;
    q0.push_back({2'b11, 32'h5555_AAAA});
    @(negedge clk);
    chk("err_m_read", m_read, 1);
    chk("err_m_addr", m_address, 34'h300);
    tick();
    m_readdatavalid = 1'b0; m_response = 2'b00; s0_read = 1'b0;

    // Reset during beat 3 of a 16-beat read.
    s0_read = 1'b1; s0_address = 34'h600; s0_burstcount = 5'd16;
    @(negedge clk);
    chk("rstmid_s0_wait", s0_waitrequest, 0);
    tick();
    s0_read = 1'b0;
    beats(0, 2, 32'hC000_0000, 2'b00);
    m_readdatavalid = 1'b1; m_readdata = 32'hC000_0002; rst_n = 1'b0; s0_read = 1'b1;
    @(negedge clk);
    chk("rstmid_s0_rdv", s0_readdatavalid, 0);
    chk("rstmid_s0_wait", s0_waitrequest, 1);
    chk("rstmid_s0_resp", s0_response, 2'b11);
    chk("rstmid_m_read", m_read, 0);
    tick();
    tick();
    rst_n = 1'b1; s0_read = 1'b0;
    tick();
    tick();
    m_readdatavalid = 1'b0;

    // Fresh contended read after reset: pointer is back on master 0.
    s0_read = 1'b1; s0_address = 34'h700; s0_burstcount = 5'd2;
    s1_read = 1'b1; s1_address = 34'h800; s1_burstcount = 5'd2;
    @(negedge clk);
    chk("post_rst_winner", m_address, 34'h700);
    chk("post_rst_s1_wait", s1_waitrequest, 1);
    tick();
    s0_read = 1'b0; s1_read = 1'b0;
    beats(0, 2, 32'hD000_0000, 2'b00);

    // Burstcount 0 behaves as a single beat; a following beat is dropped.
    s1_read = 1'b1; s1_address = 34'h900; s1_burstcount = 5'd0;
    @(negedge clk);
    chk("b0_m_addr", m_address, 34'h900);
    chk("b0_m_burst", m_burstcount, 5'd0);
    tick();
    s1_read = 1'b0;
    beats(1, 1, 32'hE000_0000, 2'b00);
    m_readdatavalid = 1'b1; m_readdata = 32'h0000_EEEE;
    @(negedge clk);
    tick();
    m_readdatavalid = 1'b0;
    tick();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("qw_drained", qw.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
